// File: rtl/minitb_ahb_slave_mem.sv
// Word-addressed AHB-lite memory responder with programmable wait states.
// OKAY-only, single slave: no hsel, no hresp.
module minitb_ahb_slave_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int WAIT_W = 4
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic [ADDR_W-1:0] bd_addr,
    output logic [DATA_W-1:0] bd_rdata,
    output logic [15:0]       xfer_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LAST} state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   hrdata_q;
    logic [15:0]         count_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                accept;
    logic                complete;
    logic                commit_wr;
    logic                rd_load;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                unused_htrans;

    // Only htrans[1] distinguishes a real transfer from IDLE/BUSY.
    assign unused_htrans = htrans[0];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_LAST: begin
                if (accept) begin
                    if (wait_cfg == '0) begin
                        state_d = S_LAST;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_cfg;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (cnt_q == WAIT_W'(1)) state_d = S_LAST;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hready = (state_q != S_WAIT);
    end

    assign accept    = hready && htrans[1];
    assign complete  = (state_q == S_LAST);
    assign commit_wr = complete && write_q;

    // hrdata loads on the edge entering LAST: from WAIT for the latched read,
    // or straight from the address phase when a zero-wait read is accepted.
    assign rd_load = ((state_q == S_WAIT) && (cnt_q == WAIT_W'(1)) && !write_q) ||
                     (accept && (wait_cfg == '0) && !hwrite);
    assign rd_addr = (state_q == S_WAIT) ? addr_q : haddr;
    assign rd_data = (commit_wr && (rd_addr == addr_q)) ? hwdata : mem[rd_addr];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
            end
            if (rd_load)  hrdata_q <= rd_data;
            if (complete) count_q  <= count_q + 16'd1;
        end
    end

    // Memory contents survive reset; a write pending at reset never reaches LAST.
    always_ff @(posedge hclk) begin
        if (commit_wr) mem[addr_q] <= hwdata;
    end

    assign hrdata     = hrdata_q;
    assign bd_rdata   = mem[bd_addr];
    assign xfer_count = count_q;

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Directed bench for minitb_ahb_slave_mem: wait states, forwarding, reset, wrap.
module tb_minitb_ahb_slave_mem;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int WAIT_W = 4;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic [WAIT_W-1:0] wait_cfg;
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_rdata;
    logic [15:0]       xfer_count;

    int errors = 0;
    int checks = 0;

    minitb_ahb_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .htrans     (htrans),
        .haddr      (haddr),
        .hwrite     (hwrite),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hready     (hready),
        .wait_cfg   (wait_cfg),
        .bd_addr    (bd_addr),
        .bd_rdata   (bd_rdata),
        .xfer_count (xfer_count)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic bd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        bd_addr = a;
        #1;
        chk(tag, bd_rdata, exp);
    endtask

    // Zero-wait single write followed by an idle address phase.
    task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        htrans = 2'b10; haddr = a; hwrite = 1'b1; wait_cfg = '0;
        tick();
        htrans = 2'b00; hwdata = d;
        tick();
    endtask

    int low;

    initial begin
        hresetn = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hwdata = '0; wait_cfg = '0; bd_addr = '0;
        tick(); tick();
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        hresetn = 1'b1;
        tick();

        // zero-wait write then read of the same word
        htrans = 2'b10; haddr = 8'h10; hwrite = 1'b1; wait_cfg = '0;
        tick();
        chk("t2_wr_hready", 32'(hready), 32'd1);
        hwdata = 32'hDEADBEEF; htrans = 2'b10; haddr = 8'h10; hwrite = 1'b0;
        tick();
        htrans = 2'b00;
        chk("t2_rd_hready", 32'(hready), 32'd1);
        chk("t2_rd_data", hrdata, 32'hDEADBEEF);
        tick();
        chk("t2_count", 32'(xfer_count), 32'd2);
        bd_chk("t2_bd", 8'h10, 32'hDEADBEEF);

        wr0(8'h20, 32'h12345678);
        wr0(8'h05, 32'h11111111);
        wr0(8'h40, 32'h40404040);
        chk("pre_count", 32'(xfer_count), 32'd5);

        // 3 wait states on a read; wait_cfg change mid-phase must not matter
        htrans = 2'b10; haddr = 8'h20; hwrite = 1'b0; wait_cfg = 4'd3;
        tick();
        htrans = 2'b00; wait_cfg = 4'd7;
        low = 0;
        while (hready === 1'b0 && low < 10) begin
            low++;
            tick();
        end
        chk("t3_low_cycles", 32'(low), 32'd3);
        chk("t3_hready", 32'(hready), 32'd1);
        chk("t3_rd_data", hrdata, 32'h12345678);
        tick();
        chk("t3_count", 32'(xfer_count), 32'd6);

        // back-to-back write/read with forwarding over old 0x11111111
        htrans = 2'b10; haddr = 8'h05; hwrite = 1'b1; wait_cfg = '0;
        tick();
        hwdata = 32'hA5A5A5A5; haddr = 8'h05; hwrite = 1'b0;
        tick();
        htrans = 2'b00;
        chk("t4_fwd_data", hrdata, 32'hA5A5A5A5);
        tick();
        chk("t4_count", 32'(xfer_count), 32'd8);
        bd_chk("t4_bd", 8'h05, 32'hA5A5A5A5);

        // write with 2 waits; read presented during waits (0x40) must be ignored
        htrans = 2'b10; haddr = 8'h30; hwrite = 1'b1; wait_cfg = 4'd2;
        tick();
        haddr = 8'h40; hwrite = 1'b0; wait_cfg = '0; hwdata = 32'hCAFEF00D;
        chk("t5_wait1", 32'(hready), 32'd0);
        tick();
        chk("t5_wait2", 32'(hready), 32'd0);
        tick();
        chk("t5_last", 32'(hready), 32'd1);
        chk("t5_hold", hrdata, 32'hA5A5A5A5);
        haddr = 8'h30;
        tick();
        htrans = 2'b00;
        chk("t5_rd_data", hrdata, 32'hCAFEF00D);
        chk("t5_rd_hready", 32'(hready), 32'd1);
        chk("t5_count_wr", 32'(xfer_count), 32'd9);
        tick();
        chk("t5_count_rd", 32'(xfer_count), 32'd10);

        // reset in the middle of a waited write
        wr0(8'h00, 32'h13572468);
        wr0(8'h50, 32'h0BADF00D);
        htrans = 2'b10; haddr = 8'h50; hwrite = 1'b1; wait_cfg = 4'd3;
        tick();
        htrans = 2'b00; hwdata = 32'h55555555;
        tick();
        chk("t1_in_wait", 32'(hready), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("t1_async_hready", 32'(hready), 32'd1);
        chk("t1_async_count", 32'(xfer_count), 32'd0);
        tick();
        hresetn = 1'b1;
        tick(); tick();
        bd_chk("t1_wr_dropped", 8'h50, 32'h0BADF00D);
        bd_chk("t1_retained", 8'h10, 32'hDEADBEEF);
        chk("t1_post_count", 32'(xfer_count), 32'd0);

        // 65536 streamed reads wrap the counter
        htrans = 2'b10; haddr = 8'h00; hwrite = 1'b0; wait_cfg = '0;
        for (int i = 0; i < 65536; i++) tick();
        htrans = 2'b00;
        tick();
        chk("t6_wrap", 32'(xfer_count), 32'd0);
        chk("t6_stream_rd", hrdata, 32'h13572468);
        wr0(8'hFF, 32'hF00DCAFE);
        bd_chk("t6_top", 8'hFF, 32'hF00DCAFE);
        bd_chk("t6_no_alias", 8'h00, 32'h13572468);
        chk("t6_count", 32'(xfer_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
